// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the serial FP adder sequencer.
package fp_ctrl_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [3:0] {
    StIdle,
    StLoadA,
    StGapA,
    StLoadB,
    StGapB,
    StArm,
    StWait,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/fp_piso.sv
// Parallel-load, serial-out shift register, LSB first. Holds the captured adder result.
module fp_piso #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              shift_i,
  output logic              serial_o,
  output logic              empty_o
);

  localparam int unsigned CntW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] data_q;
  logic [CntW-1:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      cnt_q  <= CntW'(WORD_W);
    end else if (shift_i && (cnt_q != '0)) begin
      data_q <= {1'b0, data_q[WORD_W-1:1]};
      cnt_q  <= cnt_q - CntW'(1);
    end
  end

  assign serial_o = data_q[0];
  assign empty_o  = (cnt_q == '0);

endmodule

// File: rtl/fp_serial_ctrl.sv
// Sequencer: loads operands A then B from one bitstream, starts the adder,
// then serialises the captured sum LSB first.
module fp_serial_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned ADD_TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              serial_in,
  input  logic              bit_vld_in,
  output logic              bit_rdy_out,
  output logic              ser_out,
  output logic              wr_a_out,
  output logic              wr_b_out,
  output logic              en_out,
  output logic              add_start_out,
  input  logic              add_done_in,
  input  logic [WORD_W-1:0] add_result_in,
  output logic              serial_out,
  output logic              serial_vld_out,
  input  logic              serial_rdy_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  localparam int unsigned TmrW = (ADD_TIMEOUT > 2) ? $clog2(ADD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(WORD_W - 1);
  localparam logic [TmrW-1:0]  LastTick = TmrW'(ADD_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic             err_q, err_d;
  logic             bit_rdy_q, en_q, add_start_q, busy_q, done_q;
  logic             load_res;
  logic             accept;
  logic             shift_hs;
  logic             piso_empty;

  assign accept   = bit_vld_in && bit_rdy_q;
  assign shift_hs = serial_vld_out && serial_rdy_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    load_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StLoadA;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoadA, StLoadB: begin
        if (accept) begin
          if (cnt_q == LastBit) begin
            state_d = (state_q == StLoadA) ? StGapA : StGapB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // One idle cycle lets the operand shift register finish its wrap.
      StGapA: state_d = StLoadB;
      StGapB: state_d = StArm;
      StArm: begin
        state_d = StWait;
        tmr_d   = '0;
      end
      StWait: begin
        if (add_done_in) begin
          load_res = 1'b1;
          state_d  = StShift;
          cnt_d    = '0;
        end else if (tmr_q == LastTick) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StShift: begin
        if (shift_hs) begin
          if (cnt_q == LastBit) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmr_q       <= '0;
      err_q       <= 1'b0;
      bit_rdy_q   <= 1'b0;
      en_q        <= 1'b0;
      add_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      bit_rdy_q   <= (state_d == StLoadA) || (state_d == StLoadB);
      en_q        <= (state_d == StArm) || (state_d == StWait);
      add_start_q <= (state_d == StWait) && (state_q != StWait);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
    end
  end

  fp_piso #(
    .WORD_W(WORD_W)
  ) u_piso (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (load_res),
    .data_i  (add_result_in),
    .shift_i (shift_hs),
    .serial_o(serial_out),
    .empty_o (piso_empty)
  );

  assign ser_out        = serial_in;
  assign wr_a_out       = bit_vld_in && (state_q == StLoadA);
  assign wr_b_out       = bit_vld_in && (state_q == StLoadB);
  assign bit_rdy_out    = bit_rdy_q;
  assign en_out         = en_q;
  assign add_start_out  = add_start_q;
  assign serial_vld_out = !piso_empty;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_fp_serial_ctrl.sv
// Directed bench for fp_serial_ctrl with a fixed-latency adder model.
module tb_fp_serial_ctrl;

  localparam int unsigned WordW      = 32;
  localparam int unsigned AddTimeout = 64;
  localparam int unsigned AddLat     = 5;

  logic             clk_in, rst_in, start_in, serial_in, bit_vld_in;
  logic             bit_rdy_out, ser_out, wr_a_out, wr_b_out, en_out, add_start_out;
  logic             add_done_in;
  logic [WordW-1:0] add_result_in;
  logic             serial_out, serial_vld_out, serial_rdy_in;
  logic             busy_out, done_out, err_out;

  fp_serial_ctrl #(
    .WORD_W     (WordW),
    .ADD_TIMEOUT(AddTimeout)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .serial_in     (serial_in),
    .bit_vld_in    (bit_vld_in),
    .bit_rdy_out   (bit_rdy_out),
    .ser_out       (ser_out),
    .wr_a_out      (wr_a_out),
    .wr_b_out      (wr_b_out),
    .en_out        (en_out),
    .add_start_out (add_start_out),
    .add_done_in   (add_done_in),
    .add_result_in (add_result_in),
    .serial_out    (serial_out),
    .serial_vld_out(serial_vld_out),
    .serial_rdy_in (serial_rdy_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .err_out       (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Adder model and monitor state.
  logic        adder_en;
  logic [31:0] model_res;
  int          wra, wrb, starts, dones, ens, vlds, gaps, rx_idx, hold_err, busy_gaps;
  logic [31:0] a_cap, b_cap, rx;
  logic        txn_active, prev_stall, prev_bit;

  task automatic clear_mon();
    wra = 0; wrb = 0; starts = 0; dones = 0; ens = 0; vlds = 0; gaps = 0;
    rx_idx = 0; hold_err = 0; busy_gaps = 0;
    a_cap = '0; b_cap = '0; rx = '0; txn_active = 1'b0;
  endtask

  initial begin
    add_done_in   = 1'b0;
    add_result_in = '0;
    forever begin
      @(negedge clk_in);
      if (add_start_out && adder_en) begin
        repeat (AddLat) @(posedge clk_in);
        #1;
        add_done_in   = 1'b1;
        add_result_in = model_res;
        @(posedge clk_in);
        #1;
        add_done_in = 1'b0;
      end
    end
  end

  initial begin
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    forever begin
      @(negedge clk_in);
      if (wr_a_out) begin
        if (wra < 32) a_cap[wra[4:0]] = ser_out;
        wra++;
      end
      if (wr_b_out) begin
        if (wrb < 32) b_cap[wrb[4:0]] = ser_out;
        wrb++;
      end
      if (wra >= 1 && wrb < 32 && busy_out && !bit_rdy_out) gaps++;
      if (add_start_out) starts++;
      if (done_out) dones++;
      if (en_out) ens++;
      if (serial_vld_out) vlds++;
      if (txn_active && !busy_out) busy_gaps++;
      if (prev_stall && (!serial_vld_out || serial_out !== prev_bit)) hold_err++;
      if (serial_vld_out && serial_rdy_in) begin
        if (rx_idx < 32) rx[rx_idx[4:0]] = serial_out;
        rx_idx++;
      end
      prev_stall = serial_vld_out && !serial_rdy_in;
      prev_bit   = serial_out;
    end
  end

  // Entered and left at posedge+1.
  task automatic send_word(input logic [31:0] w, input bit tog, input int nbits, output bit ok);
    bit acc;
    ok = 1'b1;
    for (int i = 0; i < nbits && ok; i++) begin
      if (tog) begin
        bit_vld_in = 1'b0;
        @(posedge clk_in);
        #1;
      end
      serial_in  = w[i];
      bit_vld_in = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk_in);
        acc = bit_rdy_out;
        @(posedge clk_in);
        #1;
      end
      if (!acc) ok = 1'b0;
    end
    bit_vld_in = 1'b0;
    serial_in  = 1'b0;
  endtask

  task automatic wait_done(input bit stall, output bit seen);
    int stalled;
    stalled = 0;
    seen    = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (stall && rx_idx == 16 && stalled < 3) begin
        serial_rdy_in = 1'b0;
        stalled++;
      end else begin
        serial_rdy_in = 1'b1;
      end
      @(negedge clk_in);
      if (done_out) seen = 1'b1;
      @(posedge clk_in);
      #1;
    end
    txn_active    = 1'b0;
    start_in      = 1'b0;
    serial_rdy_in = 1'b1;
  endtask

  task automatic do_start(input bit hold);
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    txn_active = 1'b1;
    if (!hold) start_in = 1'b0;
  endtask

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit tog, input bit stall, input bit hold);
    bit ok, seen;
    clear_mon();
    model_res = r;
    adder_en  = 1'b1;
    do_start(hold);
    check({nm, "/err_clr"}, 32'(err_out), 32'h0);
    send_word(a, tog, 32, ok);
    check({nm, "/load_a"}, 32'(ok), 32'h1);
    send_word(b, tog, 32, ok);
    check({nm, "/load_b"}, 32'(ok), 32'h1);
    wait_done(stall, seen);
    check({nm, "/done_seen"}, 32'(seen), 32'h1);
    check({nm, "/wr_a_cnt"}, wra, 32);
    check({nm, "/wr_b_cnt"}, wrb, 32);
    check({nm, "/a_cap"}, a_cap, a);
    check({nm, "/b_cap"}, b_cap, b);
    check({nm, "/gap_cycles"}, gaps, 1);
    check({nm, "/add_starts"}, starts, 1);
    check({nm, "/rx_bits"}, rx_idx, 32);
    check({nm, "/rx_word"}, rx, r);
    check({nm, "/hold_err"}, hold_err, 0);
    check({nm, "/busy_gaps"}, busy_gaps, 0);
    check({nm, "/err"}, 32'(err_out), 32'h0);
    repeat (3) begin
      @(posedge clk_in);
      #1;
    end
    check({nm, "/done_pulses"}, dones, 1);
    check({nm, "/idle_busy"}, 32'(busy_out), 32'h0);
    check({nm, "/no_restart"}, starts, 1);
  endtask

  initial begin
    bit ok, seen;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok, seen;
    rst_in        = 1'b1;
    start_in      = 1'b0;
    serial_in     = 1'b0;
    bit_vld_in    = 1'b0;
    serial_rdy_in = 1'b1;
    adder_en      = 1'b1;
    model_res     = '0;
    clear_mon();
    repeat (3) @(posedge clk_in);
    #1;
    check("reset/outs", 32'({bit_rdy_out, wr_a_out, wr_b_out, en_out, add_start_out,
                             serial_vld_out, busy_out, done_out, serial_out, ser_out,
                             err_out}), 32'h0);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    run_txn("basic", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
    run_txn("in_bp", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b1, 1'b0, 1'b0);
    run_txn("out_bp", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, 1'b0);

    // Adder never answers: error after AddTimeout WAIT cycles, no shift-out.
    clear_mon();
    adder_en = 1'b0;
    do_start(1'b0);
    send_word(32'h3F800000, 1'b0, 32, ok);
    send_word(32'h40000000, 1'b0, 32, ok);
    wait_done(1'b0, seen);
    check("tmo/done_seen", 32'(seen), 32'h1);
    check("tmo/err", 32'(err_out), 32'h1);
    check("tmo/vld_cycles", vlds, 0);
    check("tmo/en_cycles", ens, AddTimeout + 1);
    check("tmo/add_starts", starts, 1);
    repeat (4) begin
      @(posedge clk_in);
      #1;
    end
    check("tmo/err_sticky", 32'(err_out), 32'h1);
    check("tmo/done_pulses", dones, 1);
    run_txn("after_tmo", 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of loading B.
    clear_mon();
    adder_en = 1'b1;
    do_start(1'b0);
    send_word(32'h3F800000, 1'b0, 32, ok);
    send_word(32'h40000000, 1'b0, 10, ok);
    rst_in     = 1'b1;
    bit_vld_in = 1'b0;
    serial_in  = 1'b0;
    @(posedge clk_in);
    #1;
    check("midrst/outs", 32'({bit_rdy_out, wr_a_out, wr_b_out, en_out, add_start_out,
                              serial_vld_out, busy_out, done_out, serial_out, ser_out,
                              err_out}), 32'h0);
    rst_in     = 1'b0;
    txn_active = 1'b0;
    repeat (5) begin
      @(posedge clk_in);
      #1;
    end
    check("midrst/no_done", dones, 0);
    check("midrst/wr_b_cnt", wrb, 10);
    run_txn("after_rst", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);

    run_txn("start_held", 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_serial_ctrl.md
Name: fp_serial_ctrl

Overview:
Sequencer for the serial FP adder datapath. Routes one serial bitstream into the operand A and operand B serial-in shift registers, enables their parallel outputs, and starts the FP adder. It then captures the sum and serialises it back out LSB-first. Sits between the host serial interface and the operand registers / adder core.

Parameters:
WORD_W, 32, operand/result width in bits
ADD_TIMEOUT, 64, max cycles to wait for add_done_in before flagging error

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
start_in  input  1  begin a transaction; sampled only in IDLE
serial_in  input  1  host serial data bit
bit_vld_in  input  1  serial_in valid; bit accepted when bit_vld_in && bit_rdy_out
bit_rdy_out  output  1  controller ready to accept an operand bit
ser_out  output  1  operand bit forwarded to both shift registers
wr_a_out  output  1  write strobe to operand A shift register
wr_b_out  output  1  write strobe to operand B shift register
en_out  output  1  parallel-output enable to both shift registers
add_start_out  output  1  one-cycle start pulse to adder
add_done_in  input  1  adder result valid
add_result_in  input  WORD_W  adder sum
serial_out  output  1  result bit, LSB first
serial_vld_out  output  1  serial_out valid
serial_rdy_in  input  1  downstream accepts result bit when serial_vld_out && serial_rdy_in
busy_out  output  1  high in every state except IDLE
done_out  output  1  one-cycle pulse at end of transaction
err_out  output  1  adder timeout flag; sticky until next accepted start_in

Behaviour:
- Reset (rst_in=1 at clk_in edge): state=IDLE, bit counter=0, timer=0, result reg=0, err_out=0. All strobes and flags low: bit_rdy_out, wr_a_out, wr_b_out, en_out, add_start_out, serial_vld_out, busy_out, done_out. serial_out=0, ser_out=0. A reset mid-transaction abandons it; no done_out.
- ser_out = serial_in combinationally. wr_a_out = bit_vld_in in LOAD_A; wr_b_out = bit_vld_in in LOAD_B; otherwise 0.
- IDLE: start_in=1 -> LOAD_A, clear err_out and bit counter. start_in in any other state is ignored.
- LOAD_A: bit_rdy_out=1. Each accepted bit increments the 6-bit counter. The WORD_W-th accept -> GAP_A with counter=0. bit_vld_in=0 simply stalls.
- GAP_A: exactly 1 cycle, bit_rdy_out=0. This lets the shift register consume its count>31 wrap cycle. -> LOAD_B.
- LOAD_B / GAP_B: identical to LOAD_A / GAP_A, using wr_b_out. GAP_B -> ARM.
- ARM: en_out=1 for 1 cycle, because the shift register's parallel_out is registered. -> WAIT.
- WAIT: en_out=1. add_start_out=1 in the first WAIT cycle only. Timer counts from 0.
  - add_done_in=1 -> capture add_result_in, go to SHIFT.
  - Timer reaching ADD_TIMEOUT-1 without done -> err_out=1, go to DONE (no shift-out).
  - add_done_in on the same cycle as the timeout: done wins.
- SHIFT: en_out=0, serial_vld_out=1, serial_out=result[0]. On each handshake the result shifts right and the counter increments. The WORD_W-th handshake -> DONE. serial_rdy_in=0 holds bit and state.
- DONE: done_out=1 for 1 cycle, busy_out=1. -> IDLE.
- Latency with no stalls and adder latency L: start_in to done_out is 32+1+32+1+1+L+32+1 cycles.

Decomposition:
- Package fp_ctrl_pkg holds:
  - state enum (IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, ARM, WAIT, SHIFT, DONE)
  - WORD_W default
  - counter width constant CNT_W=6
- Sub-module fp_piso: parallel-load, serial-out shift register with valid/ready. Ports: load, data, shift handshake, serial_out, empty.

Test Plan:
- Basic add: start_in; send A=0x3F800000 then B=0x40000000, LSB first, continuous bit_vld_in; adder model returns 0x40400000 after 5 cycles -> exactly 32 wr_a_out and 32 wr_b_out strobes, one bit_rdy_out=0 gap after each, single add_start_out, serial output reassembles to 0x40400000, done_out high 1 cycle.
- Input backpressure: bit_vld_in toggles every other cycle during LOAD_A/LOAD_B -> same operand capture, counter advances only on accepts, result identical.
- Output backpressure: serial_rdy_in low for 3 cycles mid-SHIFT -> serial_out held stable, no bit lost or duplicated, 0x40400000 still reassembled.
- Timeout: adder never asserts done, ADD_TIMEOUT=64 -> err_out=1 after 64 WAIT cycles, no serial_vld_out, done_out pulse; next start_in clears err_out.
- Reset mid-operation: rst_in at bit 10 of LOAD_B -> next cycle IDLE, all outputs at reset values, no done_out; following full transaction succeeds.
- start_in held high during WAIT and SHIFT -> ignored, only one transaction, busy_out stays 1 until DONE.
